// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution unit: jump operator encodings,
// BHT counter reset value and the 2-bit saturating counter update.
package branch_pkg;

  localparam logic [2:0] JEQ  = 3'b000;
  localparam logic [2:0] JNE  = 3'b001;
  localparam logic [2:0] JGT  = 3'b010;
  localparam logic [2:0] JLT  = 3'b011;
  localparam logic [2:0] JGE  = 3'b100;
  localparam logic [2:0] JLE  = 3'b101;
  localparam logic [2:0] JMP  = 3'b110;
  localparam logic [2:0] JILL = 3'b111;

  // Weakly not-taken
  localparam logic [1:0] CNT_RESET = 2'b01;

  // Move a 2-bit counter toward the resolved direction, saturating at 0 and 3.
  function automatic logic [1:0] cnt_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (cnt == 2'b11) ? cnt : cnt + 2'b01;
    end else begin
      res = (cnt == 2'b00) ? cnt : cnt - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational jump condition evaluator: (op, signed_cmp, a, b) -> taken, illegal.
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [2:0]        op,
  input  logic              signed_cmp,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              taken,
  output logic              illegal
);

  logic eq;
  logic gt;
  logic lt;

  assign eq = (a == b);
  assign gt = signed_cmp ? ($signed(a) > $signed(b)) : (a > b);
  assign lt = signed_cmp ? ($signed(a) < $signed(b)) : (a < b);

  // Decode the operator; GE/LE are the complements of LT/GT.
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (op)
      JEQ:     taken = eq;
      JNE:     taken = ~eq;
      JGT:     taken = gt;
      JLT:     taken = lt;
      JGE:     taken = ~lt;
      JLE:     taken = ~gt;
      JMP:     taken = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Execute-stage branch resolution unit: one result register (S1) with
// valid/ready handshake, mispredict redirect, and a 2-bit-counter BHT that
// fetch reads combinationally and retired conditional branches train.
module branch_unit
  import branch_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned BHT_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        jump_operator,
  input  logic              signed_cmp,
  input  logic [ADDR_W-1:0] branch_pc,
  input  logic [ADDR_W-1:0] pc_destination_addr,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic              predicted_taken,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              pc_write_enabled,
  output logic [ADDR_W-1:0] pc_destination_addr_out,
  output logic              branch_taken,
  output logic              mispredict,
  output logic              illegal_op,
  input  logic [ADDR_W-1:0] pred_pc,
  output logic              pred_taken
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  logic              eval_taken;
  logic              eval_illegal;
  logic              accept;
  logic              retire;

  logic              valid_q;
  logic              taken_q;
  logic              mispred_q;
  logic              illegal_q;
  logic              cond_q;
  logic [IDX_W-1:0]  idx_q;
  logic [ADDR_W-1:0] redirect_q;

  logic [1:0]        bht_q [BHT_DEPTH];

  // Only the low index bits of the lookup address select a counter.
  logic              unused_pred_pc_bits;
  assign unused_pred_pc_bits = ^pred_pc[ADDR_W-1:IDX_W];

  branch_cond_eval #(
    .DATA_W (DATA_W)
  ) u_cond_eval (
    .op         (jump_operator),
    .signed_cmp (signed_cmp),
    .a          (operand_a),
    .b          (operand_b),
    .taken      (eval_taken),
    .illegal    (eval_illegal)
  );

  assign in_ready = ~flush & (~valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign retire   = valid_q & out_ready & ~flush;

  // S1 result register; flush drops the pending result, accept may overlap a retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      taken_q    <= 1'b0;
      mispred_q  <= 1'b0;
      illegal_q  <= 1'b0;
      cond_q     <= 1'b0;
      idx_q      <= '0;
      redirect_q <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q    <= 1'b1;
      taken_q    <= eval_taken;
      mispred_q  <= eval_taken ^ predicted_taken;
      illegal_q  <= eval_illegal;
      cond_q     <= (jump_operator <= JLE);
      idx_q      <= branch_pc[IDX_W-1:0];
      redirect_q <= eval_taken ? pc_destination_addr : branch_pc + ADDR_W'(1);
    end else if (retire) begin
      valid_q <= 1'b0;
    end
  end

  // BHT: parallel reset to weakly not-taken, trained by retired conditional branches.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= CNT_RESET;
      end
    end else if (retire && cond_q) begin
      bht_q[idx_q] <= cnt_update(bht_q[idx_q], taken_q);
    end
  end

  assign pred_taken = bht_q[pred_pc[IDX_W-1:0]][1];

  assign out_valid               = valid_q;
  assign branch_taken            = taken_q;
  assign mispredict              = mispred_q;
  assign illegal_op              = illegal_q;
  assign pc_write_enabled        = valid_q & mispred_q;
  assign pc_destination_addr_out = pc_write_enabled ? redirect_q : '0;

endmodule

// File: tb/tb_branch_unit.sv
// Directed self-checking bench for branch_unit.
module tb_branch_unit;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    jump_operator;
  logic          signed_cmp;
  logic [AW-1:0] branch_pc;
  logic [AW-1:0] pc_destination_addr;
  logic [DW-1:0] operand_a;
  logic [DW-1:0] operand_b;
  logic          predicted_taken;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic          pc_write_enabled;
  logic [AW-1:0] pc_destination_addr_out;
  logic          branch_taken;
  logic          mispredict;
  logic          illegal_op;
  logic [AW-1:0] pred_pc;
  logic          pred_taken;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_unit #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .BHT_DEPTH (DEPTH)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .in_valid                (in_valid),
    .in_ready                (in_ready),
    .jump_operator           (jump_operator),
    .signed_cmp              (signed_cmp),
    .branch_pc               (branch_pc),
    .pc_destination_addr     (pc_destination_addr),
    .operand_a               (operand_a),
    .operand_b               (operand_b),
    .predicted_taken         (predicted_taken),
    .flush                   (flush),
    .out_valid               (out_valid),
    .out_ready               (out_ready),
    .pc_write_enabled        (pc_write_enabled),
    .pc_destination_addr_out (pc_destination_addr_out),
    .branch_taken            (branch_taken),
    .mispredict              (mispredict),
    .illegal_op              (illegal_op),
    .pred_pc                 (pred_pc),
    .pred_taken              (pred_taken)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic sc, input logic [AW-1:0] pc,
                       input logic [AW-1:0] dest, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic pt);
    in_valid            = 1'b1;
    jump_operator       = op;
    signed_cmp          = sc;
    branch_pc           = pc;
    pc_destination_addr = dest;
    operand_a           = a;
    operand_b           = b;
    predicted_taken     = pt;
  endtask

  task automatic test_reset();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL reset_taken: got %b want 0", branch_taken); end
    n_checks++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL reset_mispredict: got %b want 0", mispredict); end
    n_checks++; if (illegal_op !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", illegal_op); end
    n_checks++; if (pc_write_enabled !== 1'b0) begin n_fail++; $display("FAIL reset_pcwe: got %b want 0", pc_write_enabled); end
    n_checks++; if (pc_destination_addr_out !== 16'h0000) begin n_fail++; $display("FAIL reset_dest: got %h want 0000", pc_destination_addr_out); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    for (int i = 0; i < DEPTH; i++) begin
      pred_pc = AW'(i);
      #1;
      n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred idx %0d: got %b want 0", i, pred_taken); end
    end
  endtask

  task automatic test_eq_mispredict();
    out_ready = 1'b1;
    drive(3'b000, 1'b0, 16'h0010, 16'h0040, 16'd5, 16'd5, 1'b0);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL eq_in_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL eq_valid: got %b want 1", out_valid); end
    n_checks++; if (branch_taken !== 1'b1) begin n_fail++; $display("FAIL eq_taken: got %b want 1", branch_taken); end
    n_checks++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL eq_mispredict: got %b want 1", mispredict); end
    n_checks++; if (pc_write_enabled !== 1'b1) begin n_fail++; $display("FAIL eq_pcwe: got %b want 1", pc_write_enabled); end
    n_checks++; if (pc_destination_addr_out !== 16'h0040) begin n_fail++; $display("FAIL eq_dest: got %h want 0040", pc_destination_addr_out); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL eq_retired: got %b want 0", out_valid); end
  endtask

  task automatic test_lt_signed();
    out_ready = 1'b1;
    drive(3'b011, 1'b1, 16'h0020, 16'h0080, 16'hFFFF, 16'h0001, 1'b0);
    tick();
    n_checks++; if (branch_taken !== 1'b1) begin n_fail++; $display("FAIL lt_signed_taken: got %b want 1", branch_taken); end
    n_checks++; if (pc_destination_addr_out !== 16'h0080) begin n_fail++; $display("FAIL lt_signed_dest: got %h want 0080", pc_destination_addr_out); end
    drive(3'b011, 1'b0, 16'h0021, 16'h0080, 16'hFFFF, 16'h0001, 1'b1);
    tick();
    n_checks++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL lt_unsigned_taken: got %b want 0", branch_taken); end
    n_checks++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL lt_unsigned_mispredict: got %b want 1", mispredict); end
    n_checks++; if (pc_destination_addr_out !== 16'h0022) begin n_fail++; $display("FAIL lt_unsigned_dest: got %h want 0022", pc_destination_addr_out); end
    drive(3'b011, 1'b0, 16'hFFFF, 16'h0080, 16'hFFFF, 16'h0001, 1'b1);
    tick();
    n_checks++; if (pc_write_enabled !== 1'b1) begin n_fail++; $display("FAIL wrap_pcwe: got %b want 1", pc_write_enabled); end
    n_checks++; if (pc_destination_addr_out !== 16'h0000) begin n_fail++; $display("FAIL wrap_dest: got %h want 0000", pc_destination_addr_out); end
    // Signed GE: -32768 >= 0 is false; unsigned LE 0x8000 <= 0 is false.
    drive(3'b100, 1'b1, 16'h0007, 16'h0080, 16'h8000, 16'h0000, 1'b0);
    tick();
    n_checks++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL ge_signed_taken: got %b want 0", branch_taken); end
    n_checks++; if (pc_write_enabled !== 1'b0) begin n_fail++; $display("FAIL ge_signed_pcwe: got %b want 0", pc_write_enabled); end
    drive(3'b101, 1'b0, 16'h0007, 16'h0080, 16'h8000, 16'h0000, 1'b1);
    tick();
    n_checks++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL le_unsigned_taken: got %b want 0", branch_taken); end
    n_checks++; if (pc_destination_addr_out !== 16'h0008) begin n_fail++; $display("FAIL le_unsigned_dest: got %h want 0008", pc_destination_addr_out); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_bht_training();
    logic exp_t [3] = '{1'b1, 1'b1, 1'b1};
    logic exp_n [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    out_ready = 1'b1;
    pred_pc   = 16'h0003;
    for (int i = 0; i < 3; i++) begin
      drive(3'b001, 1'b0, 16'h0003, 16'h0070, 16'd1, 16'd2, 1'b0);
      tick();
      in_valid = 1'b0;
      if (i == 0) begin
        // Retire happens on the coming edge; the read still shows the old counter.
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL bht_collision: got %b want 0", pred_taken); end
      end
      tick();
      n_checks++; if (pred_taken !== exp_t[i]) begin n_fail++; $display("FAIL bht_taken_%0d: got %b want %b", i, pred_taken, exp_t[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      drive(3'b001, 1'b0, 16'h0003, 16'h0070, 16'd7, 16'd7, 1'b1);
      tick();
      in_valid = 1'b0;
      tick();
      n_checks++; if (pred_taken !== exp_n[i]) begin n_fail++; $display("FAIL bht_not_taken_%0d: got %b want %b", i, pred_taken, exp_n[i]); end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(3'b010, 1'b0, 16'h0030, 16'h0055, 16'd9, 16'd3, 1'b0);
    tick();
    drive(3'b000, 1'b0, 16'h0031, 16'h0066, 16'd1, 16'd2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_%0d: got %b want 0", i, in_ready); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_%0d: got %b want 1", i, out_valid); end
      n_checks++; if (branch_taken !== 1'b1) begin n_fail++; $display("FAIL bp_taken_%0d: got %b want 1", i, branch_taken); end
      n_checks++; if (pc_destination_addr_out !== 16'h0055) begin n_fail++; $display("FAIL bp_dest_%0d: got %h want 0055", i, pc_destination_addr_out); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    tick();
    n_checks++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL bp_second_taken: got %b want 0", branch_taken); end
    n_checks++; if (pc_destination_addr_out !== 16'h0032) begin n_fail++; $display("FAIL bp_second_dest: got %h want 0032", pc_destination_addr_out); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(3'b110, 1'b0, AW'(16'h0200 + i), AW'(16'h0100 + i), 16'd0, 16'd1, 1'b0);
      tick();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_%0d: got %b want 1", i, out_valid); end
      n_checks++; if (pc_destination_addr_out !== AW'(16'h0100 + i)) begin n_fail++; $display("FAIL b2b_dest_%0d: got %h want %h", i, pc_destination_addr_out, AW'(16'h0100 + i)); end
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    pred_pc   = 16'h0005;
    drive(3'b000, 1'b0, 16'h0005, 16'h0090, 16'd4, 16'd4, 1'b0);
    tick();
    flush = 1'b1;
    drive(3'b110, 1'b0, 16'h0008, 16'h0099, 16'd0, 16'd0, 1'b0);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL flush_bht: got %b want 0", pred_taken); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_accept: got %b want 0", out_valid); end
  endtask

  task automatic test_jmp_illegal();
    out_ready = 1'b1;
    drive(3'b111, 1'b0, 16'h0040, 16'h00A0, 16'd1, 16'd1, 1'b1);
    tick();
    n_checks++; if (illegal_op !== 1'b1) begin n_fail++; $display("FAIL ill_flag: got %b want 1", illegal_op); end
    n_checks++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL ill_taken: got %b want 0", branch_taken); end
    n_checks++; if (pc_destination_addr_out !== 16'h0041) begin n_fail++; $display("FAIL ill_dest: got %h want 0041", pc_destination_addr_out); end
    drive(3'b111, 1'b0, 16'h0050, 16'h00A0, 16'd1, 16'd1, 1'b0);
    tick();
    n_checks++; if (pc_write_enabled !== 1'b0) begin n_fail++; $display("FAIL ill2_pcwe: got %b want 0", pc_write_enabled); end
    drive(3'b110, 1'b0, 16'h0006, 16'h0009, 16'd1, 16'd2, 1'b0);
    tick();
    in_valid = 1'b0;
    n_checks++; if (branch_taken !== 1'b1) begin n_fail++; $display("FAIL jmp_taken: got %b want 1", branch_taken); end
    n_checks++; if (illegal_op !== 1'b0) begin n_fail++; $display("FAIL jmp_illegal: got %b want 0", illegal_op); end
    n_checks++; if (pc_destination_addr_out !== 16'h0009) begin n_fail++; $display("FAIL jmp_dest: got %h want 0009", pc_destination_addr_out); end
    tick();
    pred_pc = 16'h0000;
    #1;
    n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL ill_no_train: got %b want 1", pred_taken); end
    pred_pc = 16'h0006;
    #1;
    n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL jmp_no_train: got %b want 0", pred_taken); end
  endtask

  task automatic test_rst_mid();
    out_ready = 1'b0;
    drive(3'b000, 1'b0, 16'h0010, 16'h0044, 16'd2, 16'd2, 1'b0);
    tick();
    in_valid = 1'b0;
    pred_pc  = 16'h0000;
    #1;
    n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL rst_pre_pred: got %b want 1", pred_taken); end
    rst       = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_checks++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL rst_taken: got %b want 0", branch_taken); end
    n_checks++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL rst_mispredict: got %b want 0", mispredict); end
    n_checks++; if (pc_write_enabled !== 1'b0) begin n_fail++; $display("FAIL rst_pcwe: got %b want 0", pc_write_enabled); end
    n_checks++; if (pc_destination_addr_out !== 16'h0000) begin n_fail++; $display("FAIL rst_dest: got %h want 0000", pc_destination_addr_out); end
    for (int i = 0; i < DEPTH; i++) begin
      pred_pc = AW'(i);
      #1;
      n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL rst_pred idx %0d: got %b want 0", i, pred_taken); end
    end
  endtask

  initial begin
    rst                 = 1'b1;
    in_valid            = 1'b0;
    jump_operator       = 3'b000;
    signed_cmp          = 1'b0;
    branch_pc           = '0;
    pc_destination_addr = '0;
    operand_a           = '0;
    operand_b           = '0;
    predicted_taken     = 1'b0;
    flush               = 1'b0;
    out_ready           = 1'b0;
    pred_pc             = '0;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_eq_mispredict();
    test_lt_signed();
    test_bht_training();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_jmp_illegal();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
